// File: rtl/noise_channel_gen.sv
// noise_channel_gen: channel-4 style noise generator. A programmable divider
// clocks a 15/7-bit LFSR; an envelope and a length counter shape the signed
// sample presented to the mixer on each strobe.
`timescale 1ns/1ps
module noise_channel_gen #(
  parameter int SAMPLE_W = 20,
  parameter int LFSR_W   = 15,
  parameter int LEN_W    = 6,
  parameter int TIMER_W  = 22
) (
  input  logic                       I_BITCLK,
  input  logic                       I_RESET_N,
  input  logic                       I_CLK_EN,
  input  logic                       I_STROBE,
  input  logic                       I_LEN_TICK,
  input  logic                       I_ENV_TICK,
  input  logic                       I_TRIGGER,
  input  logic [3:0]                 I_INIT_VOL,
  input  logic                       I_ENV_DIR,
  input  logic [2:0]                 I_ENV_PERIOD,
  input  logic [2:0]                 I_DIV_CODE,
  input  logic [3:0]                 I_SHIFT,
  input  logic                       I_WIDTH_MODE,
  input  logic                       I_LEN_EN,
  input  logic                       I_LEN_LOAD,
  input  logic [LEN_W-1:0]           I_LEN_DATA,
  output logic signed [SAMPLE_W-1:0] O_SAMPLE,
  output logic                       O_ACTIVE
);

  // Full length is one bit wider than the loadable value so 2^LEN_W fits.
  localparam logic [LEN_W:0]        LEN_FULL   = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0]        LEN_ONE    = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [TIMER_W-1:0]    TIMER_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};
  // One volume step is full-scale positive divided into 15 equal parts.
  localparam logic [SAMPLE_W-1:0]   AMP_STEP   = SAMPLE_W'((2**(SAMPLE_W-1) - 1) / 15);

  logic                  dac_on;
  logic                  trig_go;
  logic                  noise;
  logic                  lfsr_fb;
  logic                  lfsr_can_step;
  logic [7:0]            divisor;
  logic [TIMER_W-1:0]    period;
  logic [SAMPLE_W-1:0]   amp;

  logic [LFSR_W-1:0]     lfsr_reg, lfsr_next, lfsr_shift;
  logic [TIMER_W-1:0]    timer_reg, timer_next;
  logic [3:0]            volume_reg, volume_next;
  logic [2:0]            env_cnt_reg, env_cnt_next;
  logic [LEN_W:0]        length_reg, length_next, length_loaded;
  logic                  len_expire;
  logic                  active_reg, active_next;
  logic [SAMPLE_W-1:0]   sample_reg, sample_next;

  // The DAC is powered whenever the envelope could ever produce sound.
  assign dac_on  = (I_INIT_VOL != 4'd0) | I_ENV_DIR;
  // A trigger with the DAC off is swallowed entirely.
  assign trig_go = I_TRIGGER & dac_on;

  assign divisor       = (I_DIV_CODE == 3'd0) ? 8'd8 : {1'b0, I_DIV_CODE, 4'b0000};
  assign period        = TIMER_W'(divisor) << I_SHIFT;
  // The two largest shifts park the LFSR while the timer keeps counting.
  assign lfsr_can_step = (I_SHIFT < 4'd14);

  assign lfsr_fb = lfsr_reg[0] ^ lfsr_reg[1];
  assign noise   = ~lfsr_reg[0];
  assign amp     = AMP_STEP * SAMPLE_W'(volume_reg);

  // Shifted LFSR image; bit 6 additionally takes the feedback in short mode.
  genvar gi;
  generate
    for (gi = 0; gi < LFSR_W - 1; gi++) begin : g_shift
      if (gi == 6) begin : g_tap
        assign lfsr_shift[gi] = I_WIDTH_MODE ? lfsr_fb : lfsr_reg[gi+1];
      end else begin : g_plain
        assign lfsr_shift[gi] = lfsr_reg[gi+1];
      end
    end
  endgenerate
  assign lfsr_shift[LFSR_W-1] = lfsr_fb;

  // Divider and LFSR: trigger restarts both, otherwise count down on enables.
  always_comb begin
    timer_next = timer_reg;
    lfsr_next  = lfsr_reg;
    if (trig_go) begin
      timer_next = period;
      lfsr_next  = '1;
    end else if (I_CLK_EN) begin
      if (timer_reg <= TIMER_ONE) begin
        timer_next = period;
        if (lfsr_can_step) begin
          lfsr_next = lfsr_shift;
        end
      end else begin
        timer_next = timer_reg - TIMER_ONE;
      end
    end
  end

  // Length: a load is applied first so trigger's zero check sees the new value.
  always_comb begin
    length_loaded = I_LEN_LOAD ? (LEN_FULL - {1'b0, I_LEN_DATA}) : length_reg;
    length_next   = length_loaded;
    len_expire    = 1'b0;
    if (trig_go) begin
      if (length_loaded == '0) begin
        length_next = LEN_FULL;
      end
    end else if (I_LEN_TICK && I_LEN_EN && !I_LEN_LOAD && (length_reg != '0)) begin
      length_next = length_reg - LEN_ONE;
      len_expire  = (length_reg == LEN_ONE);
    end
  end

  // Envelope: counter divides the env tick; volume saturates at 0 and 15.
  always_comb begin
    volume_next  = volume_reg;
    env_cnt_next = env_cnt_reg;
    if (trig_go) begin
      volume_next  = I_INIT_VOL;
      env_cnt_next = I_ENV_PERIOD;
    end else if (I_ENV_TICK && (I_ENV_PERIOD != 3'd0)) begin
      if (env_cnt_reg <= 3'd1) begin
        env_cnt_next = I_ENV_PERIOD;
        if (I_ENV_DIR && (volume_reg != 4'd15)) begin
          volume_next = volume_reg + 4'd1;
        end else if (!I_ENV_DIR && (volume_reg != 4'd0)) begin
          volume_next = volume_reg - 4'd1;
        end
      end else begin
        env_cnt_next = env_cnt_reg - 3'd1;
      end
    end
  end

  // Channel status: DAC power-down overrides trigger and length expiry.
  always_comb begin
    active_next = active_reg;
    if (trig_go) begin
      active_next = 1'b1;
    end else if (len_expire) begin
      active_next = 1'b0;
    end
    if (!dac_on) begin
      active_next = 1'b0;
    end
  end

  // Sample: captured on strobe from the state present before this edge.
  always_comb begin
    sample_next = sample_reg;
    if (I_STROBE) begin
      if (!active_reg) begin
        sample_next = '0;
      end else if (noise) begin
        sample_next = amp;
      end else begin
        sample_next = -amp;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge I_BITCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      lfsr_reg    <= '1;
      timer_reg   <= '0;
      volume_reg  <= '0;
      env_cnt_reg <= '0;
      length_reg  <= '0;
      active_reg  <= 1'b0;
      sample_reg  <= '0;
    end else begin
      lfsr_reg    <= lfsr_next;
      timer_reg   <= timer_next;
      volume_reg  <= volume_next;
      env_cnt_reg <= env_cnt_next;
      length_reg  <= length_next;
      active_reg  <= active_next;
      sample_reg  <= sample_next;
    end
  end

  assign O_SAMPLE = sample_reg;
  assign O_ACTIVE = active_reg;

endmodule
